// File: rtl/imem_boot_ctrl.sv
// Boot controller for the shared 8-bit instruction-memory port: loads a byte-stream image,
// then hands the port to the core fetch path and releases the core from reset-hold.
module imem_boot_ctrl #(
    parameter int unsigned        ADDR_W    = 8,
    parameter int unsigned        DATA_W    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    output logic              cpu_run,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_instr,
    output logic              cpu_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned       CNT_W        = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  IDLE_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  IDLE_SAT     = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W:0]   FULL_LEN     = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   remaining_q;
    logic [CNT_W-1:0]  idle_cnt_q;
    logic              ld_ready_q;
    logic              cpu_run_q;
    logic              cpu_stall_q;
    logic              ld_done_q;
    logic              ld_err_q;

    logic              accept;
    logic              last_byte;
    logic [ADDR_W:0]   remaining_d;

    // A zero length encodes a full 2^ADDR_W image, hence the extra bit on remaining.
    assign remaining_d = (ld_len == '0) ? FULL_LEN : {1'b0, ld_len};
    assign accept      = ld_ready_q & ld_valid;
    assign last_byte   = accept & (remaining_q == (ADDR_W+1)'(1));

    // NOTE: every register below is assigned with <= so all state updates see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= BASE_ADDR;
            remaining_q <= '0;
            idle_cnt_q  <= '0;
            ld_ready_q  <= 1'b0;
            cpu_run_q   <= 1'b0;
            cpu_stall_q <= 1'b1;
            ld_done_q   <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            ld_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (ld_start) begin
                        state_q     <= ST_LOAD;
                        remaining_q <= remaining_d;
                        ptr_q       <= BASE_ADDR;
                        idle_cnt_q  <= '0;
                        ld_ready_q  <= 1'b1;
                        cpu_run_q   <= 1'b0;
                        cpu_stall_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        ptr_q       <= ptr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - (ADDR_W+1)'(1);
                        idle_cnt_q  <= '0;
                        // Last-byte accept takes priority over an expiring idle count.
                        if (last_byte) begin
                            state_q     <= ST_RUN;
                            ld_done_q   <= 1'b1;
                            ld_ready_q  <= 1'b0;
                            cpu_run_q   <= 1'b1;
                            cpu_stall_q <= 1'b0;
                        end
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        state_q    <= ST_IDLE;
                        ld_err_q   <= 1'b1;
                        ld_ready_q <= 1'b0;
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q != IDLE_SAT) begin
                        idle_cnt_q <= idle_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    ld_ready_q  <= 1'b0;
                    cpu_run_q   <= 1'b0;
                    cpu_stall_q <= 1'b1;
                end
            endcase
        end
    end

    assign ld_ready  = ld_ready_q;
    assign ld_done   = ld_done_q;
    assign ld_err    = ld_err_q;
    assign cpu_run   = cpu_run_q;
    assign cpu_stall = cpu_stall_q;

    // NOTE: mem_we is combinational on the handshake so imem captures the byte at the accepting edge.
    assign mem_we    = accept;
    assign mem_addr  = (state_q == ST_LOAD) ? ptr_q : cpu_addr;
    assign mem_wdata = (state_q == ST_LOAD) ? ld_data : '0;
    assign cpu_instr = cpu_run_q ? mem_rdata : '0;

    a_we_only_in_load : assert property (@(posedge clk) disable iff (reset)
        mem_we |-> (state_q == ST_LOAD));
    a_load_has_bytes : assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_LOAD) |-> (remaining_q != '0));

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: two instances (default and BASE_ADDR=0xF0/TIMEOUT=4)
// share stimulus, each with its own behavioural imem.
module tb_imem_boot_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_start;
    logic [7:0] ld_len;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic [7:0] cpu_addr;

    logic       ld_ready_a, ld_done_a, ld_err_a, cpu_run_a, cpu_stall_a, mem_we_a;
    logic [7:0] cpu_instr_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic       ld_ready_b, ld_done_b, ld_err_b, cpu_run_b, cpu_stall_b, mem_we_b;
    logic [7:0] cpu_instr_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    imem_boot_ctrl u_dut_a (
        .clk(clk), .reset(reset),
        .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready_a), .ld_done(ld_done_a), .ld_err(ld_err_a),
        .cpu_run(cpu_run_a), .cpu_addr(cpu_addr), .cpu_instr(cpu_instr_a), .cpu_stall(cpu_stall_a),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    imem_boot_ctrl #(.BASE_ADDR(8'hF0), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready_b), .ld_done(ld_done_b), .ld_err(ld_err_b),
        .cpu_run(cpu_run_b), .cpu_addr(cpu_addr), .cpu_instr(cpu_instr_b), .cpu_stall(cpu_stall_b),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 8'h00;
                mem_b[i] <= 8'h00;
            end
        end else begin
            if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
            if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
        end
    end

    assign mem_rdata_a = mem_a[mem_addr_a];
    assign mem_rdata_b = mem_b[mem_addr_b];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        ld_start = 1'b0;
        ld_len   = 8'h00;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        cpu_addr = 8'h00;
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Leaves the caller at the start of the first RUN cycle, inputs idle.
    task automatic quick_load(input logic [7:0] len, input logic [7:0] first);
        cyc();
        ld_start = 1'b1;
        ld_len   = len;
        for (int i = 0; i < int'(len); i++) begin
            cyc();
            ld_start = 1'b0;
            ld_valid = 1'b1;
            ld_data  = first + 8'(i);
        end
        cyc();
        ld_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] img1 [3];
        logic [7:0] d;
        img1[0] = 8'hA1; img1[1] = 8'hB2; img1[2] = 8'hC3;
        reset = 1'b1;

        // 1: reset state, back-to-back load, combinational fetch
        do_reset();
        #1;
        check("rst_ready",  {31'd0, ld_ready_a},  32'd0);
        check("rst_run",    {31'd0, cpu_run_a},   32'd0);
        check("rst_stall",  {31'd0, cpu_stall_a}, 32'd1);
        check("rst_we",     {31'd0, mem_we_a},    32'd0);
        check("rst_done",   {31'd0, ld_done_a},   32'd0);
        check("rst_err",    {31'd0, ld_err_a},    32'd0);
        check("rst_instr",  {24'd0, cpu_instr_a}, 32'd0);
        check("rst_wdata",  {24'd0, mem_wdata_a}, 32'd0);
        cyc();
        ld_start = 1'b1;
        ld_len   = 8'd3;
        #1;
        check("t1_idle_ready", {31'd0, ld_ready_a}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            ld_start = 1'b0;
            ld_valid = 1'b1;
            ld_data  = img1[i];
            #1;
            check("t1_we",    {31'd0, mem_we_a},    32'd1);
            check("t1_addr",  {24'd0, mem_addr_a},  i);
            check("t1_wdata", {24'd0, mem_wdata_a}, {24'd0, img1[i]});
            check("t1_stall", {31'd0, cpu_stall_a}, 32'd1);
            check("t1_done0", {31'd0, ld_done_a},   32'd0);
        end
        cyc();
        ld_valid = 1'b0;
        cpu_addr = 8'd1;
        #1;
        check("t1_done",  {31'd0, ld_done_a},   32'd1);
        check("t1_run",   {31'd0, cpu_run_a},   32'd1);
        check("t1_stall_run", {31'd0, cpu_stall_a}, 32'd0);
        check("t1_ready_run", {31'd0, ld_ready_a},  32'd0);
        check("t1_instr1", {24'd0, cpu_instr_a}, 32'hB2);
        check("t1_we_run", {31'd0, mem_we_a},    32'd0);
        cyc();
        cpu_addr = 8'd2;
        #1;
        check("t1_done_pulse", {31'd0, ld_done_a}, 32'd0);
        check("t1_instr2", {24'd0, cpu_instr_a}, 32'hC3);
        cpu_addr = 8'd0;
        #1;
        check("t1_instr0", {24'd0, cpu_instr_a}, 32'hA1);

        // 2: five-cycle gaps between bytes, no timeout with TIMEOUT=255
        do_reset();
        cyc();
        ld_start = 1'b1;
        ld_len   = 8'd3;
        for (int i = 0; i < 3; i++) begin
            cyc();
            ld_start = 1'b0;
            ld_valid = 1'b1;
            ld_data  = 8'h11 * 8'(i + 1);
            #1;
            check("t2_we", {31'd0, mem_we_a}, 32'd1);
            if (i < 2) begin
                for (int g = 0; g < 5; g++) begin
                    cyc();
                    ld_valid = 1'b0;
                    #1;
                    check("t2_gap_stall", {31'd0, cpu_stall_a}, 32'd1);
                    check("t2_gap_err",   {31'd0, ld_err_a},    32'd0);
                    check("t2_gap_ready", {31'd0, ld_ready_a},  32'd1);
                end
            end
        end
        cyc();
        ld_valid = 1'b0;
        cpu_addr = 8'd0;
        #1;
        check("t2_done", {31'd0, ld_done_a},   32'd1);
        check("t2_m0",   {24'd0, cpu_instr_a}, 32'h11);
        cpu_addr = 8'd1;
        #1;
        check("t2_m1",   {24'd0, cpu_instr_a}, 32'h22);
        cpu_addr = 8'd2;
        #1;
        check("t2_m2",   {24'd0, cpu_instr_a}, 32'h33);

        // 3: TIMEOUT=4 instance, one of two bytes then silence
        do_reset();
        cyc();
        ld_start = 1'b1;
        ld_len   = 8'd2;
        cyc();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 8'h77;
        #1;
        check("t3_we",   {31'd0, mem_we_b},   32'd1);
        check("t3_addr", {24'd0, mem_addr_b}, 32'hF0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            ld_valid = 1'b0;
            #1;
            check("t3_err_early", {31'd0, ld_err_b},   32'd0);
            check("t3_ready",     {31'd0, ld_ready_b}, 32'd1);
        end
        cyc();
        #1;
        check("t3_err",       {31'd0, ld_err_b},    32'd1);
        check("t3_idle_ready", {31'd0, ld_ready_b}, 32'd0);
        check("t3_run",       {31'd0, cpu_run_b},   32'd0);
        check("t3_stall",     {31'd0, cpu_stall_b}, 32'd1);
        check("t3_kept",      {24'd0, mem_b[8'hF0]}, 32'h77);
        cyc();
        #1;
        check("t3_err_pulse", {31'd0, ld_err_b}, 32'd0);

        // 4: ld_len=0 -> 256 bytes from 0xF0 wrapping through 0x00
        do_reset();
        cyc();
        ld_start = 1'b1;
        ld_len   = 8'd0;
        for (int i = 0; i < 256; i++) begin
            cyc();
            ld_start = 1'b0;
            ld_valid = 1'b1;
            ld_data  = 8'(i * 7 + 3);
            #1;
            check("t4_addr", {24'd0, mem_addr_b}, {24'd0, 8'(8'hF0 + i)});
            check("t4_done_early", {31'd0, ld_done_b}, 32'd0);
        end
        cyc();
        ld_valid = 1'b0;
        cpu_addr = 8'hF0;
        #1;
        check("t4_done",  {31'd0, ld_done_b},   32'd1);
        check("t4_run",   {31'd0, cpu_run_b},   32'd1);
        check("t4_mF0",   {24'd0, cpu_instr_b}, 32'h03);
        cpu_addr = 8'hEF;
        #1;
        check("t4_mEF",   {24'd0, cpu_instr_b}, 32'hFC);
        cpu_addr = 8'h00;
        #1;
        check("t4_m00",   {24'd0, cpu_instr_b}, 32'h73);

        // 5: reload from RUN
        do_reset();
        quick_load(8'd1, 8'h10);
        #1;
        check("t5_run0", {31'd0, cpu_run_a}, 32'd1);
        cyc();
        ld_start = 1'b1;
        ld_len   = 8'd1;
        #1;
        check("t5_run_still", {31'd0, cpu_run_a}, 32'd1);
        cyc();
        ld_start = 1'b0;
        #1;
        check("t5_load_run",   {31'd0, cpu_run_a},   32'd0);
        check("t5_load_stall", {31'd0, cpu_stall_a}, 32'd1);
        cyc();
        ld_valid = 1'b1;
        ld_data  = 8'h5A;
        #1;
        check("t5_load_run2", {31'd0, cpu_run_a},  32'd0);
        check("t5_we",        {31'd0, mem_we_a},   32'd1);
        check("t5_addr",      {24'd0, mem_addr_a}, 32'd0);
        cyc();
        ld_valid = 1'b0;
        cpu_addr = 8'd0;
        #1;
        check("t5_done",  {31'd0, ld_done_a},   32'd1);
        check("t5_run",   {31'd0, cpu_run_a},   32'd1);
        check("t5_instr", {24'd0, cpu_instr_a}, 32'h5A);

        // 6: reset mid-load, then a clean restart
        do_reset();
        cyc();
        ld_start = 1'b1;
        ld_len   = 8'd4;
        for (int i = 0; i < 2; i++) begin
            cyc();
            ld_start = 1'b0;
            ld_valid = 1'b1;
            ld_data  = 8'h90 + 8'(i);
        end
        cyc();
        ld_data = 8'h92;
        reset   = 1'b1;
        #1;
        check("t6_ready", {31'd0, ld_ready_a},  32'd0);
        check("t6_we",    {31'd0, mem_we_a},    32'd0);
        check("t6_run",   {31'd0, cpu_run_a},   32'd0);
        check("t6_stall", {31'd0, cpu_stall_a}, 32'd1);
        check("t6_done",  {31'd0, ld_done_a},   32'd0);
        check("t6_err",   {31'd0, ld_err_a},    32'd0);
        check("t6_addr",  {24'd0, mem_addr_a},  32'd0);
        check("t6_wdata", {24'd0, mem_wdata_a}, 32'd0);
        cyc();
        reset    = 1'b0;
        ld_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            check("t6_no_done", {31'd0, ld_done_a},  32'd0);
            check("t6_idle",    {31'd0, ld_ready_a}, 32'd0);
        end
        quick_load(8'd4, 8'h40);
        cpu_addr = 8'd3;
        #1;
        check("t6_redone", {31'd0, ld_done_a},   32'd1);
        check("t6_m3",     {24'd0, cpu_instr_a}, 32'h43);
        cpu_addr = 8'd0;
        #1;
        d = cpu_instr_a;
        check("t6_m0",     {24'd0, d}, 32'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
